word_stream_receiver: RTL and testbench
=======================================

WORD_STREAM_RECEIVER -- requirements
Module: word_stream_receiver

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each data word.
REQ-002 Parameter DEPTH, default 4: number of buffer entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  word offered by the upstream registered driver.
REQ-006 in_valid  input  1  in_data holds a valid word this cycle.
REQ-007 in_ready  output  1  receiver accepts a word this cycle.
REQ-008 out_data  output  WIDTH  oldest buffered word (head).
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  downstream consumes the head word this cycle.
REQ-011 level  output  $clog2(DEPTH)+1  current occupancy; present only when WORD_RX_LEVEL_EN is defined.

Function
REQ-012 Push SHALL occur on a clock edge where in_valid && in_ready; pop SHALL occur on an edge where out_valid && out_ready.
REQ-013 in_ready SHALL equal (occupancy < DEPTH) and out_valid SHALL equal (occupancy != 0); both SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.
REQ-014 Words SHALL leave in arrival order, bit-exact; no word SHALL be dropped or duplicated.
REQ-015 Latency: a word pushed into an empty buffer at edge N SHALL appear on out_data with out_valid=1 after edge N; there is no same-cycle bypass.
REQ-016 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 Occupancy update: push only -> +1; pop only -> -1; push and pop on the same edge -> unchanged, with the head advanced and the new word written at the tail.
REQ-018 Full (occupancy=DEPTH): in_ready=0, so no push; a pop SHALL still occur and re-assert in_ready in the next cycle.
REQ-019 Empty (occupancy=0): out_valid=0; out_ready SHALL be ignored and out_data is don't-care.
REQ-020 Read and write pointers are $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 without an extra idle cycle.
REQ-021 in_data SHALL be ignored when in_valid=0; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-022 Asserting reset SHALL immediately, independent of clk, clear occupancy and both pointers, drive out_valid=0 and in_ready=1, and clear level to 0 when present.
REQ-023 Buffer storage is not reset; out_data is don't-care while out_valid=0.
REQ-024 Reset asserted mid-transfer SHALL discard all buffered words; no pre-reset word SHALL appear after reset is released.
REQ-025 The first push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro WORD_RX_LEVEL_EN defined: port level SHALL be present and SHALL equal the registered occupancy, updated on the same edge as the push/pop that changes it.
REQ-027 Macro WORD_RX_LEVEL_EN undefined: port level and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 After reset, push 0x00000001..0x00000004 on consecutive cycles with out_ready=0 -> in_ready=0 after the 4th push; level=4 when enabled.
REQ-029 From full, hold out_ready=1 for 4 cycles -> out_data reads 0x1, 0x2, 0x3, 0x4 in order; then out_valid=0 and in_ready=1.
REQ-030 Continuous streaming with in_valid=out_ready=1 for 10 cycles, data 0xA0..0xA9 -> output order preserved, occupancy holds at 1, pointers wrap twice.
REQ-031 At occupancy=2, push 0xDEADBEEF while popping -> occupancy stays 2 and 0xDEADBEEF emerges after the 2 older words.
REQ-032 Assert reset between edges at occupancy=3 -> out_valid=0 immediately; after release, push 0x55 -> the next output is 0x55.
REQ-033 Toggle in_valid and out_ready randomly for 1000 cycles against a scoreboard -> zero mismatches, and out_data is stable whenever a stall occurs.

Source files
------------

// File: rtl/word_stream_receiver_if.sv
// Valid/ready word stream bundle: upstream push side plus downstream pop side.
interface word_stream_receiver_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/word_stream_receiver.sv
// Word stream receiver: DEPTH-entry in-order buffer with registered flags.
// Optional occupancy port `level` when WORD_RX_LEVEL_EN is defined.
module word_stream_receiver #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    word_stream_receiver_if.slave  bus
`ifdef WORD_RX_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_w;
    logic             out_valid_w;
    logic             push;
    logic             pop;

    // Flags come only from the registered count, never from in_valid/out_ready.
    assign in_ready_w   = (count_q != CW'(DEPTH));
    assign out_valid_w  = (count_q != '0);
    assign push         = bus.in_valid && in_ready_w;
    assign pop          = bus.out_ready && out_valid_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef WORD_RX_LEVEL_EN
    assign level = count_q;
`endif
endmodule

// File: tb/tb_word_stream_receiver.sv
// Self-checking bench for word_stream_receiver against a queue model.
// Build with WORD_RX_LEVEL_EN defined to also check the level port.
module tb_word_stream_receiver;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic [2:0] dut_lvl;
    int n_cmp;
    int n_err;
    logic [WIDTH-1:0] q[$];

    word_stream_receiver_if #(.WIDTH(WIDTH)) bus ();

`ifdef WORD_RX_LEVEL_EN
    logic [2:0] level;
    word_stream_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .level(level)
    );
    assign dut_lvl = level;
`else
    word_stream_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    assign dut_lvl = '0;
`endif

    wire [4:0] dut_stat = {bus.out_valid, bus.in_ready, dut_lvl};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Expected {out_valid, in_ready, level} from the model occupancy.
    function automatic logic [4:0] exp_stat();
        logic [2:0] l;
`ifdef WORD_RX_LEVEL_EN
        l = 3'(q.size());
`else
        l = '0;
`endif
        return {q.size() != 0, q.size() < DEPTH, l};
    endfunction

    // One rising edge; the model applies the spec's push/pop rules.
    task automatic tick();
        bit pv;
        bit po;
        logic [WIDTH-1:0] d;
        pv = bus.in_valid && (q.size() < DEPTH);
        po = bus.out_ready && (q.size() != 0);
        d  = bus.in_data;
        @(posedge clk);
        if (po) void'(q.pop_front());
        if (pv) q.push_back(d);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (dut_stat !== 5'b01000) begin
            n_err++;
            $display("FAIL reset_stat: got %b want %b", dut_stat, 5'b01000);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        #1;
        n_cmp++;
        if (dut_stat !== exp_stat()) begin
            n_err++;
            $display("FAIL post_reset_stat: got %b want %b", dut_stat, exp_stat());
        end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] v;
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            v = 32'(i + 1);
            bus.in_valid = 1'b1;
            bus.in_data  = v;
            tick();
            n_cmp++;
            if (dut_stat !== exp_stat()) begin
                n_err++;
                $display("FAIL fill_stat[%0d]: got %b want %b", i, dut_stat, exp_stat());
            end
            n_cmp++;
            if (bus.out_data !== 32'h1) begin
                n_err++;
                $display("FAIL fill_head[%0d]: got %h want 00000001", i, bus.out_data);
            end
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: got %b want 0", bus.in_ready);
        end
        bus.in_data = 32'h99;
        tick();
        n_cmp++;
        if (dut_stat !== exp_stat() || q.size() != DEPTH) begin
            n_err++;
            $display("FAIL full_push_blocked: got %b want %b", dut_stat, exp_stat());
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] e;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            e = 32'(i + 1);
            n_cmp++;
            if (bus.out_data !== e || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL drain[%0d]: got %h/%b want %h/1", i, bus.out_data, bus.out_valid, e);
            end
            tick();
        end
        n_cmp++;
        if (dut_stat !== 5'b01000) begin
            n_err++;
            $display("FAIL drain_empty: got %b want 01000", dut_stat);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] e;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                e = 32'hA0 + 32'(i - 1);
                n_cmp++;
                if (bus.out_data !== e) begin
                    n_err++;
                    $display("FAIL stream_data[%0d]: got %h want %h", i, bus.out_data, e);
                end
            end
            bus.in_data = 32'hA0 + 32'(i);
            tick();
            n_cmp++;
            if (dut_stat !== exp_stat() || q.size() != 1) begin
                n_err++;
                $display("FAIL stream_stat[%0d]: got %b want %b", i, dut_stat, exp_stat());
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_data !== 32'hA9) begin
            n_err++;
            $display("FAIL stream_last: got %h want 000000a9", bus.out_data);
        end
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_simul();
        logic [WIDTH-1:0] exp_seq [3];
        exp_seq[0] = 32'h11;
        exp_seq[1] = 32'h22;
        exp_seq[2] = 32'hDEADBEEF;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h11;
        tick();
        bus.in_data   = 32'h22;
        tick();
        bus.in_data   = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        n_cmp++;
        if (dut_stat !== exp_stat() || q.size() != 2) begin
            n_err++;
            $display("FAIL simul_level: got %b want %b", dut_stat, exp_stat());
        end
        for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (bus.out_data !== exp_seq[i]) begin
                n_err++;
                $display("FAIL simul_order[%0d]: got %h want %h", i, bus.out_data, exp_seq[i]);
            end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_data = 32'h300 + 32'(i);
            tick();
        end
        bus.in_data   = 32'h3FF;
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (dut_stat !== exp_stat() || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop_stat: got %b want %b", dut_stat, exp_stat());
        end
        n_cmp++;
        if (bus.out_data !== 32'h301) begin
            n_err++;
            $display("FAIL full_pop_head: got %h want 00000301", bus.out_data);
        end
        bus.in_valid = 1'b0;
        while (q.size() != 0) tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 32'h700 + 32'(i);
            tick();
        end
        idle_inputs();
        #3;
        reset = 1'b1;
        #1;
        q.delete();
        n_cmp++;
        if (dut_stat !== 5'b01000) begin
            n_err++;
            $display("FAIL mid_reset_async: got %b want 01000", dut_stat);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h55;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (dut_stat !== exp_stat() || bus.out_data !== 32'h55) begin
            n_err++;
            $display("FAIL mid_reset_first: got %b/%h want %b/00000055", dut_stat, bus.out_data, exp_stat());
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (dut_stat !== 5'b01000) begin
            n_err++;
            $display("FAIL mid_reset_stale: got %b want 01000", dut_stat);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit stall;
        logic [WIDTH-1:0] hold;
        for (int c = 0; c < 1000; c++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = $urandom;
            bus.out_ready = 1'($urandom_range(0, 1));
            stall = (q.size() != 0) && !bus.out_ready;
            hold  = (q.size() != 0) ? q[0] : '0;
            tick();
            n_cmp++;
            if (dut_stat !== exp_stat()) begin
                n_err++;
                $display("FAIL rand_stat[%0d]: got %b want %b", c, dut_stat, exp_stat());
            end
            if (q.size() != 0) begin
                n_cmp++;
                if (bus.out_data !== q[0]) begin
                    n_err++;
                    $display("FAIL rand_data[%0d]: got %h want %h", c, bus.out_data, q[0]);
                end
            end
            if (stall) begin
                n_cmp++;
                if (bus.out_data !== hold) begin
                    n_err++;
                    $display("FAIL rand_stall[%0d]: got %h want %h", c, bus.out_data, hold);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_simul();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
